fruit_blitter: RTL and testbench

Sprite blitter that copies one fruit sprite into the frame buffer. It scans a FRUIT_W × FRUIT_H sprite in raster order and drives the sprite-ROM lookup port (print_true, current_type, current_figure_index). It takes the returned colour and issues one frame-buffer write per visible, non-transparent pixel, with back-pressure from the frame-buffer write port. It sits between the game-logic draw scheduler (start/done) and the frame-buffer arbiter.

---
 rtl/fruit_blitter.sv | 174 +++++++++++++++++
 tb/tb_fruit_blitter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fruit_blitter.sv
`default_nettype none
// ============================================================================
// fruit_blitter -- raster-scans one sprite through the ROM lookup port and
// streams visible, non-transparent pixels to the frame buffer.
// Revision 1.0
// ============================================================================
module fruit_blitter #(
  parameter int                  FB_DATAW    = 16,
  parameter int                  FRUIT_W     = 32,
  parameter int                  FRUIT_H     = 32,
  parameter int                  FRUIT_SIZE  = FRUIT_W * FRUIT_H,
  parameter int                  FRUIT_DEPTH = $clog2(FRUIT_SIZE),
  parameter int                  type_index  = 2,
  parameter int                  SCREEN_W    = 640,
  parameter int                  SCREEN_H    = 480,
  parameter int                  X_W         = 10,
  parameter int                  Y_W         = 9,
  parameter int                  FB_ADDRW    = 19,
  parameter logic [FB_DATAW-1:0] TRANSPARENT = '0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [X_W-1:0]         pos_x,
  input  logic [Y_W-1:0]         pos_y,
  input  logic [type_index-1:0]  sprite_type,
  output logic                   busy,
  output logic                   done,
  output logic                   print_true,
  output logic [type_index-1:0]  current_type,
  output logic [FRUIT_DEPTH-1:0] current_figure_index,
  input  logic [FB_DATAW-1:0]    color,
  output logic                   fb_we,
  output logic [FB_ADDRW-1:0]    fb_addr,
  output logic [FB_DATAW-1:0]    fb_wdata,
  input  logic                   fb_ready
);

  localparam int COL_W = (FRUIT_W > 1) ? $clog2(FRUIT_W) : 1;
  localparam int ROW_W = (FRUIT_H > 1) ? $clog2(FRUIT_H) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [X_W-1:0]        pos_x_q, pos_x_d;
  logic [Y_W-1:0]        pos_y_q, pos_y_d;
  logic [type_index-1:0] type_q, type_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  we_q, we_d;
  logic [FB_ADDRW-1:0]   addr_q, addr_d;
  logic [FB_DATAW-1:0]   wdata_q, wdata_d;

  logic                  stall;
  logic                  last_col;
  logic                  last_pix;
  logic                  keep;
  logic [X_W:0]          sum_x;
  logic [Y_W:0]          sum_y;
  logic [FB_ADDRW-1:0]   pix_addr;
  logic [FRUIT_DEPTH-1:0] scan_idx;

  // Stage 0: one extra bit on each coordinate sum so clipping never wraps.
  assign sum_x    = {1'b0, pos_x_q} + (X_W+1)'(col_q);
  assign sum_y    = {1'b0, pos_y_q} + (Y_W+1)'(row_q);
  assign keep     = (color != TRANSPARENT)
                 && (sum_x < (X_W+1)'(SCREEN_W))
                 && (sum_y < (Y_W+1)'(SCREEN_H));
  assign pix_addr = FB_ADDRW'(sum_y) * FB_ADDRW'(SCREEN_W) + FB_ADDRW'(sum_x);
  assign scan_idx = FRUIT_DEPTH'(row_q) * FRUIT_DEPTH'(FRUIT_W) + FRUIT_DEPTH'(col_q);

  assign stall    = we_q && !fb_ready;
  assign last_col = (col_q == COL_W'(FRUIT_W - 1));
  assign last_pix = last_col && (row_q == ROW_W'(FRUIT_H - 1));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (!stall && last_pix) state_d = S_DRAIN;
      S_DRAIN: if (!stall) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy                 = (state_q != S_IDLE);
    done                 = (state_q == S_DONE);
    print_true           = (state_q == S_SCAN);
    current_figure_index = (state_q == S_SCAN) ? scan_idx : '0;
  end

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    type_d  = type_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pos_x_d = pos_x;
          pos_y_d = pos_y;
          type_d  = sprite_type;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_SCAN: begin
        if (!stall) begin
          we_d = keep;
          if (keep) begin
            addr_d  = pix_addr;
            wdata_d = color;
          end
          if (last_col) begin
            col_d = '0;
            row_d = last_pix ? '0 : row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) we_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      type_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      type_q  <= type_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign current_type = type_q;
  assign fb_we        = we_q;
  assign fb_addr      = addr_q;
  assign fb_wdata     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_fruit_blitter.sv
`default_nettype none
// Bench for fruit_blitter on a 4x4 sprite: directed scenarios plus randomized
// blits, all compared each cycle against a pixel-level model of the copy.
module tb_fruit_blitter;

  localparam int FW  = 4;
  localparam int FH  = 4;
  localparam int SZ  = FW * FH;
  localparam int DEP = $clog2(SZ);

  logic           Clk = 1'b0;
  logic           Reset = 1'b0;
  logic           start = 1'b0;
  logic [9:0]     pos_x = '0;
  logic [8:0]     pos_y = '0;
  logic [1:0]     sprite_type = '0;
  logic           busy, done, print_true;
  logic [1:0]     current_type;
  logic [DEP-1:0] current_figure_index;
  logic [15:0]    color;
  logic           fb_we;
  logic [18:0]    fb_addr;
  logic [15:0]    fb_wdata;
  logic           fb_ready = 1'b1;

  fruit_blitter #(.FRUIT_W(FW), .FRUIT_H(FH)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
    .sprite_type(sprite_type), .busy(busy), .done(done), .print_true(print_true),
    .current_type(current_type), .current_figure_index(current_figure_index),
    .color(color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_ready(fb_ready)
  );

  always #5 Clk = ~Clk;

  logic [15:0] rom [4][SZ];
  assign color = print_true ? rom[current_type][current_figure_index] : 16'hDEAD;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: what the blit must look like, pixel by pixel
  bit m_valid = 0, m_act = 0, m_done = 0, m_pend = 0, m_zero = 0;
  int m_ptr = 0, m_lx = 0, m_ly = 0, m_lt = 0, m_addr = 0, m_data = 0;

  int b_start = 0, b_writes = 0, b_done_rel = -1;
  bit b_done_seen = 0;
  int b_addrs[$];
  bit rdy_rand = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qat(input int i);
    return (i < b_addrs.size()) ? b_addrs[i] : -1;
  endfunction

  function automatic int count_addr(input int a);
    int n = 0;
    foreach (b_addrs[i]) if (b_addrs[i] == a) n++;
    return n;
  endfunction

  task automatic model_step();
    bit scan;
    int r, c, x, y;
    logic [15:0] col;
    if (m_valid) begin
      scan = m_act && !m_done && (m_ptr < SZ);
      chk("busy", busy, m_act);
      chk("done", done, m_done);
      chk("print_true", print_true, scan);
      chk("index", current_figure_index, scan ? m_ptr : 0);
      chk("current_type", current_type, m_lt);
      chk("fb_we", fb_we, m_pend);
      if (m_pend) begin
        chk("fb_addr", fb_addr, m_addr);
        chk("fb_wdata", fb_wdata, m_data);
      end
      if (m_zero) begin
        chk("rst_addr", fb_addr, 0);
        chk("rst_wdata", fb_wdata, 0);
      end
    end
    if (fb_we === 1'b1 && fb_ready) begin
      b_writes++;
      b_addrs.push_back(int'(fb_addr));
    end
    if (done === 1'b1 && !b_done_seen) begin
      b_done_seen = 1;
      b_done_rel  = cyc - b_start;
    end
    if (!Reset) begin
      m_valid = 1; m_act = 0; m_done = 0; m_ptr = 0; m_pend = 0; m_lt = 0; m_zero = 1;
    end else begin
      m_zero = 0;
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_ptr = 0;
          m_lx = int'(pos_x); m_ly = int'(pos_y); m_lt = int'(sprite_type);
          b_start = cyc; b_writes = 0; b_done_seen = 0; b_done_rel = -1;
          b_addrs.delete();
        end
      end else if (m_done) begin
        m_act = 0; m_done = 0;
      end else if (!(m_pend && !fb_ready)) begin
        if (m_ptr < SZ) begin
          r = m_ptr / FW; c = m_ptr % FW;
          x = m_lx + c;   y = m_ly + r;
          col = rom[m_lt][m_ptr];
          m_pend = (col != 16'd0) && (x < 640) && (y < 480);
          if (m_pend) begin
            m_addr = y * 640 + x;
            m_data = int'(col);
          end
          m_ptr++;
        end else begin
          m_pend = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge Clk);
    cyc++;
    model_step();
    @(posedge Clk);
    #2;
    if (rdy_rand) fb_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_blit(input int x, input int y, input int t);
    pos_x = 10'(x); pos_y = 9'(y); sprite_type = 2'(t);
    start = 1'b1;
    step();
    start = 1'b0;
    pos_x = 10'($urandom); pos_y = 9'($urandom); sprite_type = 2'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!b_done_seen && n < budget) begin
      if (rdy_rand && busy) start = $urandom_range(0, 1) != 0;
      step();
      n++;
    end
    start = 1'b0;
    if (!b_done_seen) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done after %0d cycles, required within budget", n);
    end
    step();
  endtask

  task automatic fill_nonzero();
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < SZ; i++) rom[t][i] = 16'(t * 256 + i + 1);
  endtask

  task automatic fill_random();
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < SZ; i++)
        rom[t][i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
  endtask

  initial begin
    int n;
    logic [18:0]    hold_addr;
    logic [15:0]    hold_data;
    logic [DEP-1:0] hold_idx;
    fill_nonzero();
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_print", print_true, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_addr0", fb_addr, 0);
    chk("rst_idx", current_figure_index, 0);
    Reset = 1'b1;
    step();

    // Basic blit
    start_blit(10, 20, 1);
    wait_done(100);
    chk("basic_writes", b_writes, 16);
    chk("basic_first", qat(0), 12810);
    chk("basic_last", qat(15), 14733);
    chk("basic_done_rel", b_done_rel, 18);
    chk("busy_after_done", busy, 0);

    // Transparency
    rom[1][0] = 16'd0;
    rom[1][5] = 16'd0;
    start_blit(10, 20, 1);
    wait_done(100);
    chk("transp_writes", b_writes, 14);
    chk("transp_done_rel", b_done_rel, 18);
    chk("transp_no_12810", count_addr(12810), 0);
    chk("transp_no_13451", count_addr(13451), 0);
    fill_nonzero();

    // Clipping at the bottom-right corner
    start_blit(638, 478, 0);
    wait_done(100);
    chk("clip_writes", b_writes, 4);
    chk("clip_a0", qat(0), 306558);
    chk("clip_a1", qat(1), 306559);
    chk("clip_a2", qat(2), 307198);
    chk("clip_a3", qat(3), 307199);
    chk("clip_done_rel", b_done_rel, 18);

    // Back-pressure: three refused cycles on write #5
    start_blit(10, 20, 2);
    n = 0;
    while (!(b_writes == 4 && fb_we) && n < 50) begin step(); n++; end
    fb_ready = 1'b0;
    hold_addr = fb_addr; hold_data = fb_wdata; hold_idx = current_figure_index;
    chk("bp_addr5", hold_addr, 13450);
    chk("bp_data5", hold_data, rom[2][4]);
    chk("bp_idx5", hold_idx, 5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_we", fb_we, 1);
      chk("bp_hold_addr", fb_addr, hold_addr);
      chk("bp_hold_data", fb_wdata, hold_data);
      chk("bp_hold_idx", current_figure_index, hold_idx);
    end
    fb_ready = 1'b1;
    wait_done(100);
    chk("bp_writes", b_writes, 16);
    chk("bp_done_rel", b_done_rel, 21);
    for (int i = 0; i < 16; i++) chk("bp_order", qat(i), (20 + i / 4) * 640 + 10 + i % 4);

    // Start pulse while busy is ignored
    start_blit(10, 20, 1);
    repeat (4) step();
    pos_x = 10'd100; pos_y = 9'd100; sprite_type = 2'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    chk("ign_writes", b_writes, 16);
    chk("ign_first", qat(0), 12810);
    chk("ign_last", qat(15), 14733);
    chk("ign_done_rel", b_done_rel, 18);
    repeat (20) step();
    chk("ign_no_second", busy, 0);

    // Reset while stalled mid-scan
    start_blit(5, 6, 2);
    n = 0;
    while (!fb_we && n < 50) begin step(); n++; end
    fb_ready = 1'b0;
    step();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_we", fb_we, 0);
    chk("mrst_addr", fb_addr, 0);
    chk("mrst_wdata", fb_wdata, 0);
    chk("mrst_print", print_true, 0);
    chk("mrst_idx", current_figure_index, 0);
    chk("mrst_type", current_type, 0);
    fb_ready = 1'b1;
    start_blit(10, 20, 1);
    wait_done(100);
    chk("mrst_writes", b_writes, 16);
    chk("mrst_first", qat(0), 12810);
    chk("mrst_done_rel", b_done_rel, 18);

    // Randomized blits with random back-pressure and start spam
    rdy_rand = 1;
    for (int k = 0; k < 25; k++) begin
      int x, y;
      fill_random();
      x = ($urandom_range(0, 1) != 0) ? $urandom_range(630, 639) : $urandom_range(0, 639);
      y = ($urandom_range(0, 1) != 0) ? $urandom_range(470, 479) : $urandom_range(0, 479);
      start_blit(x, y, $urandom_range(0, 3));
      wait_done(2000);
    end
    rdy_rand = 0;
    fb_ready = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
